// File: rtl/serial_substractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a borrow flop,
// DIFF = A - B - BIN produced LSB first over WIDTH cycles with start/busy/done.
module serial_substractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW,
  output logic             OVF
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] sd;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             d_bit;
  logic             b_bit;
  logic             last_bit;
  logic [WIDTH-1:0] sd_shifted;

  assign d_bit      = sa[0] ^ sb[0] ^ br;
  assign b_bit      = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign last_bit   = (cnt == CNT_W'(WIDTH - 1));
  // The final bit completes the result without waiting for another shift.
  assign sd_shifted = {d_bit, sd};

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    case (state)
      IDLE: if (START) state_next = RUN;
      RUN: begin
        BUSY = 1'b1;
        if (last_bit) state_next = FIN;
      end
      FIN: begin
        DONE       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sa     <= '0;
      sb     <= '0;
      sd     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      DIFF   <= '0;
      BORROW <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            sa  <= A;
            sb  <= B;
            br  <= BIN;
            sd  <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= b_bit;
          sd  <= sd_shifted[WIDTH-1:1];
          cnt <= last_bit ? '0 : cnt + CNT_W'(1);
          // br here is still the borrow into the MSB stage.
          if (last_bit) begin
            DIFF   <= sd_shifted;
            BORROW <= b_bit;
            OVF    <= br ^ b_bit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_substractor.sv
// Self-checking bench for serial_substractor: directed vectors, mid-run reset,
// random 8-bit operations and an exhaustive 4-bit sweep against an arithmetic model.
module tb_serial_substractor;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST;

  logic       start8, bin8, busy8, done8, borrow8, ovf8;
  logic [7:0] a8, b8, diff8;

  logic       start4, bin4, busy4, done4, borrow4, ovf4;
  logic [3:0] a4, b4, diff4;

  int passCount  = 0;
  int checkCount = 0;
  logic [7:0] prev8;

  serial_substractor #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .START(start8), .A(a8), .B(b8), .BIN(bin8),
    .BUSY(busy8), .DONE(done8), .DIFF(diff8), .BORROW(borrow8), .OVF(ovf8)
  );

  serial_substractor #(.WIDTH(4)) dut4 (
    .CLK(CLK), .RST(RST), .START(start4), .A(a4), .B(b4), .BIN(bin4),
    .BUSY(busy4), .DONE(done4), .DIFF(diff4), .BORROW(borrow4), .OVF(ovf4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic void refModel(input int w, input int a, input int b, input int bin,
                                   output int diff, output int borrow, output int ovf);
    int full, sa, sb, sr, half;
    half   = 1 << (w - 1);
    full   = a - b - bin;
    diff   = full & ((1 << w) - 1);
    borrow = (full < 0) ? 1 : 0;
    sa     = (a >= half) ? a - (1 << w) : a;
    sb     = (b >= half) ? b - (1 << w) : b;
    sr     = sa - sb - bin;
    ovf    = (sr < -half || sr > half - 1) ? 1 : 0;
  endfunction

  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                                input bit pokeStart);
    int ed, eb, eo;
    refModel(8, int'(a), int'(b), int'(bin), ed, eb, eo);
    start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
    step();
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    for (int k = 1; k <= 8; k++) begin
      checkOutput("busy8_run", 32'(busy8), 32'd1);
      checkOutput("done8_run", 32'(done8), 32'd0);
      checkOutput("diff8_hold", 32'(diff8), 32'(prev8));
      if (pokeStart && k == 3) begin start8 = 1'b1; a8 = 8'h55; b8 = 8'($urandom); end
      if (pokeStart && k == 4) start8 = 1'b0;
      step();
    end
    checkOutput("done8_pulse", 32'(done8), 32'd1);
    checkOutput("busy8_fin", 32'(busy8), 32'd0);
    checkOutput("diff8", 32'(diff8), 32'(ed));
    checkOutput("borrow8", 32'(borrow8), 32'(eb));
    checkOutput("ovf8", 32'(ovf8), 32'(eo));
    prev8 = 8'(ed);
    step();
    checkOutput("done8_end", 32'(done8), 32'd0);
    checkOutput("busy8_end", 32'(busy8), 32'd0);
  endtask

  task automatic applyStimulus4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    int ed, eb, eo;
    refModel(4, int'(a), int'(b), int'(bin), ed, eb, eo);
    start4 = 1'b1; a4 = a; b4 = b; bin4 = bin;
    step();
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    for (int k = 1; k <= 4; k++) begin
      checkOutput("done4_timing", 32'(done4), 32'd0);
      step();
    end
    checkOutput("done4_pulse", 32'(done4), 32'd1);
    checkOutput("res4", {29'd0, borrow4, ovf4, 1'b0} | 32'(diff4) << 3,
                {29'd0, 1'(eb), 1'(eo), 1'b0} | 32'(ed) << 3);
    step();
  endtask

  initial begin
    RST = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    prev8 = '0;
    step();
    step();
    RST = 1'b0;
    checkOutput("rst_busy8", 32'(busy8), 32'd0);
    checkOutput("rst_done8", 32'(done8), 32'd0);
    checkOutput("rst_diff8", 32'(diff8), 32'd0);
    checkOutput("rst_borrow8", 32'(borrow8), 32'd0);
    checkOutput("rst_ovf8", 32'(ovf8), 32'd0);
    checkOutput("rst_busy4", 32'(busy4), 32'd0);

    applyStimulus8(8'h05, 8'h03, 1'b0, 1'b0);
    applyStimulus8(8'h03, 8'h05, 1'b0, 1'b0);
    applyStimulus8(8'h80, 8'h01, 1'b0, 1'b0);
    applyStimulus8(8'h7F, 8'hFF, 1'b0, 1'b0);
    applyStimulus8(8'h00, 8'h00, 1'b1, 1'b1);

    // Abort mid-run: reset lands on edge 4 after acceptance.
    start8 = 1'b1; a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0;
    step();
    start8 = 1'b0;
    step(); step(); step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    checkOutput("abort_busy", 32'(busy8), 32'd0);
    checkOutput("abort_done", 32'(done8), 32'd0);
    checkOutput("abort_diff", 32'(diff8), 32'd0);
    checkOutput("abort_borrow", 32'(borrow8), 32'd0);
    checkOutput("abort_ovf", 32'(ovf8), 32'd0);
    prev8 = '0;
    step();
    checkOutput("abort_idle_done", 32'(done8), 32'd0);
    applyStimulus8(8'h05, 8'h03, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++)
      applyStimulus8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          applyStimulus4(4'(a), 4'(b), 1'(c));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
